mac_tx_arbiter: RTL and testbench

- Packet-granular round-robin arbiter that shares the Ethernet MAC transmit Avalon-ST port between two 32-bit packet sources (src0: MPU result stream, src1: control/status reply stream).
- Sits between the MPU datapath and the MAC transmit interface.
- Locks the grant for a whole packet and withholds new packet starts while the MAC TX FIFO is almost full.
- Discards orphan beats (no SOP) and keeps saturating statistics counters.

---
 rtl/mpu_eth_pkg.sv | 20 ++
 rtl/sat_counter.sv | 27 ++
 rtl/mac_tx_arbiter.sv | 124 ++++++++++++
 tb/tb_mac_tx_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_eth_pkg.sv
// Shared types for the MPU Ethernet transmit path: arbiter states and the
// Avalon-ST beat layout used between the MPU datapath and the MAC.
package mpu_eth_pkg;

    localparam int ETH_DATA_W = 32;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

    typedef struct packed {
        logic [ETH_DATA_W-1:0] data;
        logic                  sop;
        logic                  eop;
        logic [1:0]            empty;
        logic                  error;
    } st_beat_t;

endpackage

// File: rtl/sat_counter.sv
// Statistics counter that adds 0, 1 or 2 per cycle and sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W:0] MAX = {1'b0, {CNT_W{1'b1}}};

    // One extra bit so a +2 near the top cannot wrap before the compare.
    logic [CNT_W:0] sum;
    assign sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (sum > MAX)
            cnt <= '1;
        else
            cnt <= sum[CNT_W-1:0];
    end

endmodule

// File: rtl/mac_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the MAC transmit Avalon-ST port
// between the MPU result stream (src0) and the control/status stream (src1).
module mac_tx_arbiter
    import mpu_eth_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter bit FAIR_START = 1'b0
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic [ETH_DATA_W-1:0] src0_data,
    input  logic                  src0_valid,
    output logic                  src0_ready,
    input  logic                  src0_startofpacket,
    input  logic                  src0_endofpacket,
    input  logic [1:0]            src0_empty,
    input  logic                  src0_error,
    input  logic [ETH_DATA_W-1:0] src1_data,
    input  logic                  src1_valid,
    output logic                  src1_ready,
    input  logic                  src1_startofpacket,
    input  logic                  src1_endofpacket,
    input  logic [1:0]            src1_empty,
    input  logic                  src1_error,
    output logic [ETH_DATA_W-1:0] transmit_data,
    output logic                  transmit_valid,
    input  logic                  transmit_ready,
    output logic                  transmit_startofpacket,
    output logic                  transmit_endofpacket,
    output logic [1:0]            transmit_empty,
    output logic                  transmit_error,
    output logic                  tx_mac_misc_connection_ff_tx_crc_fwd,
    input  logic                  tx_mac_misc_connection_ff_tx_a_full,
    output logic [CNT_W-1:0]      pkt_cnt0,
    output logic [CNT_W-1:0]      pkt_cnt1,
    output logic [CNT_W-1:0]      orphan_cnt
);

    arb_state_t state, state_nxt;
    logic       grant, grant_nxt;
    logic       last_grant, last_grant_nxt;
    st_beat_t   beat0, beat1, sel_beat, tx_beat;
    logic       sel_valid;
    logic       req0, req1;
    logic [1:0] orphan_inc, pkt_inc0, pkt_inc1;

    assign beat0 = '{data: src0_data, sop: src0_startofpacket, eop: src0_endofpacket,
                     empty: src0_empty, error: src0_error};
    assign beat1 = '{data: src1_data, sop: src1_startofpacket, eop: src1_endofpacket,
                     empty: src1_empty, error: src1_error};

    assign sel_beat  = grant ? beat1 : beat0;
    assign sel_valid = grant ? src1_valid : src0_valid;
    assign req0      = src0_valid && src0_startofpacket;
    assign req1      = src1_valid && src1_startofpacket;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state      <= ARB_IDLE;
            grant      <= 1'b0;
            last_grant <= ~FAIR_START;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        tx_beat        = '0;
        transmit_valid = 1'b0;
        src0_ready     = 1'b0;
        src1_ready     = 1'b0;
        orphan_inc     = 2'd0;
        pkt_inc0       = 2'd0;
        pkt_inc1       = 2'd0;
        case (state)
            ARB_IDLE: begin
                // Orphans are swallowed here; reset gating keeps ready low while held in reset.
                src0_ready = reset_reset_n && src0_valid && !src0_startofpacket;
                src1_ready = reset_reset_n && src1_valid && !src1_startofpacket;
                orphan_inc = {1'b0, src0_ready} + {1'b0, src1_ready};
                if (!tx_mac_misc_connection_ff_tx_a_full && (req0 || req1)) begin
                    state_nxt = ARB_BUSY;
                    grant_nxt = (req0 && req1) ? ~last_grant : req1;
                end
            end
            ARB_BUSY: begin
                tx_beat        = sel_beat;
                transmit_valid = sel_valid;
                if (grant)
                    src1_ready = transmit_ready;
                else
                    src0_ready = transmit_ready;
                if (sel_valid && transmit_ready && sel_beat.eop) begin
                    state_nxt      = ARB_IDLE;
                    last_grant_nxt = grant;
                    pkt_inc0       = {1'b0, ~grant};
                    pkt_inc1       = {1'b0, grant};
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    assign transmit_data                        = tx_beat.data;
    assign transmit_startofpacket               = tx_beat.sop;
    assign transmit_endofpacket                 = tx_beat.eop;
    assign transmit_empty                       = tx_beat.empty;
    assign transmit_error                       = tx_beat.error;
    assign tx_mac_misc_connection_ff_tx_crc_fwd = 1'b0;

    sat_counter #(.CNT_W(CNT_W)) u_pkt_cnt0 (
        .clk(clk_clk), .rst_n(reset_reset_n), .inc(pkt_inc0), .cnt(pkt_cnt0));
    sat_counter #(.CNT_W(CNT_W)) u_pkt_cnt1 (
        .clk(clk_clk), .rst_n(reset_reset_n), .inc(pkt_inc1), .cnt(pkt_cnt1));
    sat_counter #(.CNT_W(CNT_W)) u_orphan_cnt (
        .clk(clk_clk), .rst_n(reset_reset_n), .inc(orphan_inc), .cnt(orphan_cnt));

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Directed bench for mac_tx_arbiter; a second narrow-counter instance on the
// same inputs exercises counter saturation in few cycles.
module tb_mac_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s0_data = '0, s1_data = '0;
    logic        s0_valid = 0, s1_valid = 0, s0_sop = 0, s1_sop = 0, s0_eop = 0, s1_eop = 0;
    logic [1:0]  s0_empty = '0, s1_empty = '0;
    logic        s0_error = 0, s1_error = 0;
    logic        tx_ready = 1'b1;
    logic        a_full = 1'b0;

    logic        s0_ready, s1_ready, tx_valid, tx_sop, tx_eop, tx_error, crc_fwd;
    logic [31:0] tx_data;
    logic [1:0]  tx_empty;
    logic [15:0] pkt_cnt0, pkt_cnt1, orphan_cnt;

    logic        b_s0_ready, b_s1_ready, b_tx_valid, b_tx_sop, b_tx_eop, b_tx_error, b_crc_fwd;
    logic [31:0] b_tx_data;
    logic [1:0]  b_tx_empty;
    logic [1:0]  b_pkt_cnt0, b_pkt_cnt1, b_orphan_cnt;

    int n_checks = 0;
    int n_pass = 0;
    int exp0 = 0, exp1 = 0, exp_orph = 0;

    always #5 clk = ~clk;

    mac_tx_arbiter #(.CNT_W(16), .FAIR_START(1'b0)) dut (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .src0_data(s0_data), .src0_valid(s0_valid), .src0_ready(s0_ready),
        .src0_startofpacket(s0_sop), .src0_endofpacket(s0_eop),
        .src0_empty(s0_empty), .src0_error(s0_error),
        .src1_data(s1_data), .src1_valid(s1_valid), .src1_ready(s1_ready),
        .src1_startofpacket(s1_sop), .src1_endofpacket(s1_eop),
        .src1_empty(s1_empty), .src1_error(s1_error),
        .transmit_data(tx_data), .transmit_valid(tx_valid), .transmit_ready(tx_ready),
        .transmit_startofpacket(tx_sop), .transmit_endofpacket(tx_eop),
        .transmit_empty(tx_empty), .transmit_error(tx_error),
        .tx_mac_misc_connection_ff_tx_crc_fwd(crc_fwd),
        .tx_mac_misc_connection_ff_tx_a_full(a_full),
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .orphan_cnt(orphan_cnt));

    mac_tx_arbiter #(.CNT_W(2), .FAIR_START(1'b0)) dut_sat (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .src0_data(s0_data), .src0_valid(s0_valid), .src0_ready(b_s0_ready),
        .src0_startofpacket(s0_sop), .src0_endofpacket(s0_eop),
        .src0_empty(s0_empty), .src0_error(s0_error),
        .src1_data(s1_data), .src1_valid(s1_valid), .src1_ready(b_s1_ready),
        .src1_startofpacket(s1_sop), .src1_endofpacket(s1_eop),
        .src1_empty(s1_empty), .src1_error(s1_error),
        .transmit_data(b_tx_data), .transmit_valid(b_tx_valid), .transmit_ready(tx_ready),
        .transmit_startofpacket(b_tx_sop), .transmit_endofpacket(b_tx_eop),
        .transmit_empty(b_tx_empty), .transmit_error(b_tx_error),
        .tx_mac_misc_connection_ff_tx_crc_fwd(b_crc_fwd),
        .tx_mac_misc_connection_ff_tx_a_full(a_full),
        .pkt_cnt0(b_pkt_cnt0), .pkt_cnt1(b_pkt_cnt1), .orphan_cnt(b_orphan_cnt));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic drive(input int s, input logic v, input logic sop, input logic eop,
                         input logic [31:0] d, input logic [1:0] e, input logic err);
        if (s == 0) begin
            s0_valid = v; s0_sop = sop; s0_eop = eop; s0_data = d; s0_empty = e; s0_error = err;
        end else begin
            s1_valid = v; s1_sop = sop; s1_eop = eop; s1_data = d; s1_empty = e; s1_error = err;
        end
    endtask

    function automatic logic rdy(input int s);
        return (s == 0) ? s0_ready : s1_ready;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Called in an IDLE cycle: presents SOP, checks the arbitration cycle,
    // then walks every beat and checks it on transmit_*.
    task automatic run_pkt(input int s, input int nb, input logic [31:0] base,
                           input bit toggle, input bit afull_mid);
        int i = 0;
        int guard = 0;
        drive(s, 1'b1, 1'b1, nb == 1, base, 2'd0, 1'b0);
        #1;
        check("arb_cycle_valid", {63'd0, tx_valid}, 64'd0);
        check("arb_cycle_sop_held", {63'd0, rdy(s)}, 64'd0);
        tick();
        while (i < nb && guard < 4 * nb) begin
            tx_ready = toggle ? (guard % 2 == 0) : 1'b1;
            if (afull_mid && i == 1) a_full = 1'b1;
            drive(s, 1'b1, i == 0, i == nb - 1, base + 32'(i), 2'(i), (i % 2) == 1);
            #1;
            check("beat_valid", {63'd0, tx_valid}, 64'd1);
            check("beat_data", {32'd0, tx_data}, {32'd0, base + 32'(i)});
            check("beat_flags", {59'd0, tx_sop, tx_eop, tx_empty, tx_error},
                  {59'd0, i == 0, i == nb - 1, 2'(i), (i % 2) == 1});
            check("granted_ready", {63'd0, rdy(s)}, {63'd0, tx_ready});
            check("other_ready_held", {63'd0, rdy(1 - s)}, 64'd0);
            if (tx_ready) i++;
            guard++;
            tick();
        end
        check("beats_delivered", 64'(i), 64'(nb));
        drive(s, 1'b0, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0);
        tx_ready = 1'b1;
        if (s == 0) exp0++; else exp1++;
        #1;
        check("post_eop_idle", {63'd0, tx_valid}, 64'd0);
        check("pkt_cnt0", 64'(pkt_cnt0), 64'(exp0));
        check("pkt_cnt1", 64'(pkt_cnt1), 64'(exp1));
        check("sat_pkt_cnt0", 64'(b_pkt_cnt0), 64'(sat3(exp0)));
        check("sat_pkt_cnt1", 64'(b_pkt_cnt1), 64'(sat3(exp1)));
    endtask

    initial begin
        int last;
        int w;
        // Reset state.
        #1;
        check("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
        check("rst_tx_fields", {27'd0, tx_data, tx_sop, tx_eop, tx_empty, tx_error}, 64'd0);
        check("rst_ready", {62'd0, s0_ready, s1_ready}, 64'd0);
        check("rst_counters", {16'd0, pkt_cnt0, pkt_cnt1, orphan_cnt}, 64'd0);
        check("crc_fwd_tied", {63'd0, crc_fwd}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Both sources request every round: strict alternation starting at src0.
        last = 1;
        for (int r = 0; r < 6; r++) begin
            w = 1 - last;
            drive(0, 1'b1, 1'b1, 1'b0, 32'hA000_0000 | (r << 8), 2'd0, 1'b0);
            drive(1, 1'b1, 1'b1, 1'b0, 32'hB100_0000 | (r << 8), 2'd0, 1'b0);
            run_pkt(w, 2, (w == 0 ? 32'hA000_0000 : 32'hB100_0000) | (r << 8), 1'b0, 1'b0);
            check("rr_winner", 64'(w), 64'(r % 2));
            last = w;
        end
        drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0);
        tick();

        // Lone 4-beat packet on src0 (also drives narrow counter past saturation).
        run_pkt(0, 4, 32'h1234_5670, 1'b0, 1'b0);
        tick();

        // Almost-full blocks the start but not a packet in flight.
        a_full = 1'b1;
        drive(1, 1'b1, 1'b1, 1'b0, 32'hC000_0000, 2'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("afull_blocks_valid", {63'd0, tx_valid}, 64'd0);
            check("afull_blocks_ready", {63'd0, s1_ready}, 64'd0);
            tick();
        end
        a_full = 1'b0;
        run_pkt(1, 3, 32'hC000_0000, 1'b0, 1'b1);
        a_full = 1'b0;
        tick();

        // Backpressure toggling every other cycle on a 6-beat packet.
        run_pkt(0, 6, 32'hD000_0010, 1'b1, 1'b0);
        tick();

        // Orphans while IDLE: accepted and dropped.
        for (int k = 0; k < 3; k++) begin
            drive(1, 1'b1, 1'b0, 1'b0, 32'hEEEE_0000 + 32'(k), 2'd0, 1'b0);
            #1;
            check("orphan_ready", {63'd0, s1_ready}, 64'd1);
            check("orphan_no_tx", {63'd0, tx_valid}, 64'd0);
            tick();
        end
        exp_orph = 3;
        check("orphan_cnt3", 64'(orphan_cnt), 64'(exp_orph));
        drive(0, 1'b1, 1'b0, 1'b0, 32'hEEEE_1000, 2'd0, 1'b0);
        #1;
        check("dual_orphan_ready", {62'd0, s0_ready, s1_ready}, 64'd3);
        tick();
        exp_orph = 5;
        check("orphan_cnt_plus2", 64'(orphan_cnt), 64'(exp_orph));
        check("sat_orphan_cnt", 64'(b_orphan_cnt), 64'(sat3(exp_orph)));

        // Orphan on src1 discarded while src0 wins arbitration, then held in BUSY.
        run_pkt(0, 2, 32'hF000_0000, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0);
        exp_orph = 6;
        check("orphan_with_arb", 64'(orphan_cnt), 64'(exp_orph));
        tick();

        // Reset on beat 3 of a packet truncates it immediately.
        drive(0, 1'b1, 1'b1, 1'b0, 32'h5500_0000, 2'd0, 1'b0);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(0, 1'b1, k == 0, 1'b0, 32'h5500_0000 + 32'(k), 2'd0, 1'b0);
            tick();
        end
        drive(0, 1'b1, 1'b0, 1'b0, 32'h5500_0002, 2'd0, 1'b0);
        #1;
        check("beat3_on_wire", {32'd0, tx_data}, 64'h5500_0002);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", {63'd0, tx_valid}, 64'd0);
        check("rst_mid_fields", {27'd0, tx_data, tx_sop, tx_eop, tx_empty, tx_error}, 64'd0);
        check("rst_mid_ready", {62'd0, s0_ready, s1_ready}, 64'd0);
        check("rst_mid_counters", {16'd0, pkt_cnt0, pkt_cnt1, orphan_cnt}, 64'd0);
        drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0);
        exp0 = 0; exp1 = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        // Fresh single-beat packet after reset.
        run_pkt(0, 1, 32'h0BAD_F00D, 1'b0, 1'b0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
